icon_blitter: RTL and testbench

- Reader-side companion to icon_rotator.
- On a start request, it sweeps the rotator's 8-bit icon address space (16x16 icon, 256 RGB565 pixels) and captures each returned pixelData word.
- It streams each pixel, with absolute screen coordinates, to the LCD/framebuffer writer using a valid/ready handshake.
- It latches the snake heading at start, so the rotator's direction cannot change mid-icon.

---
 rtl/icon_pkg.sv | 34 +++
 rtl/icon_blitter_if.sv | 31 +++
 rtl/icon_latency_counter.sv | 29 ++
 rtl/icon_blitter.sv | 161 ++++++++++++++++
 tb/tb_icon_blitter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icon_pkg.sv
// Shared constants, state encoding and helpers for the icon blitter and its neighbours.
// Pure declarations: no logic, no latency, no flow control.
package icon_pkg;

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b1000;

    localparam int ICON_SIZE   = 16;
    localparam int ICON_PIXELS = 256;

    localparam logic [15:0] RGB_BLACK   = 16'h0000;
    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;

    localparam int SCREEN_TILES_X = 15;
    localparam int SCREEN_TILES_Y = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } blit_state_t;

    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/icon_blitter_if.sv
// Start/rotator/pixel-sink signal bundle for icon_blitter.
// master = blitter side, slave = controller, rotator and framebuffer side.
interface icon_blitter_if;
    logic        start;
    logic [3:0]  tileX;
    logic [4:0]  tileY;
    logic [3:0]  directionIn;
    logic [3:0]  direction;
    logic [7:0]  address;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic [7:0]  pixelX;
    logic [8:0]  pixelY;
    logic [15:0] pixelRawData;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  start, tileX, tileY, directionIn, pixelData, pixelReady,
        output direction, address, pixelWrite, pixelX, pixelY, pixelRawData,
        output busy, done, error
    );

    modport slave (
        output start, tileX, tileY, directionIn, pixelData, pixelReady,
        input  direction, address, pixelWrite, pixelX, pixelY, pixelRawData,
        input  busy, done, error
    );
endinterface

// File: rtl/icon_latency_counter.sv
// Down-counter giving the pixelData sample strobe ROM_LATENCY edges after each load.
// Strobe is combinational from the count; no backpressure, reloads take priority.
module icon_latency_counter #(
    parameter int ROM_LATENCY = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic count_en,
    output logic strobe
);

    localparam logic [1:0] LOAD_VAL = 2'(ROM_LATENCY - 1);

    logic [1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 2'd0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (count_en && (cnt != 2'd0)) begin
            cnt <= cnt - 2'd1;
        end
    end

    assign strobe = count_en && (cnt == 2'd0);

endmodule

// File: rtl/icon_blitter.sv
// Sweeps a 16x16 rotator icon and streams non-transparent pixels with screen coordinates.
// ROM_LATENCY+1 cycles per written pixel; holds pixelWrite and data stable until pixelReady.
module icon_blitter
    import icon_pkg::*;
#(
    parameter int          ROM_LATENCY        = 1,
    parameter bit          TRANSPARENT_EN     = 1'b1,
    parameter logic [15:0] TRANSPARENT_COLOUR = RGB_MAGENTA,
    parameter int          TILES_X            = SCREEN_TILES_X,
    parameter int          TILES_Y            = SCREEN_TILES_Y
) (
    input  logic           clock,
    input  logic           reset_n,
    icon_blitter_if.master bus
);

    blit_state_t state, state_nxt;
    logic [7:0]  addr_q, addr_nxt;
    logic [3:0]  dir_q, dir_nxt;
    logic [3:0]  tile_x_q, tile_x_nxt;
    logic [4:0]  tile_y_q, tile_y_nxt;
    logic        wr_q, wr_nxt;
    logic [7:0]  px_q, px_nxt;
    logic [8:0]  py_q, py_nxt;
    logic [15:0] dat_q, dat_nxt;
    logic        busy_q, busy_nxt;
    logic        done_q, done_nxt;
    logic        err_q, err_nxt;
    logic        lat_load;
    logic        sample;
    logic        tile_bad;
    logic        last_pixel;

    icon_latency_counter #(.ROM_LATENCY(ROM_LATENCY)) u_lat (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (lat_load),
        .count_en (state == WAIT),
        .strobe   (sample)
    );

    assign tile_bad   = (32'(bus.tileX) >= 32'(TILES_X)) || (32'(bus.tileY) >= 32'(TILES_Y));
    assign last_pixel = (addr_q == 8'hFF);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_q   <= 8'd0;
            dir_q    <= DIR_RIGHT;
            tile_x_q <= 4'd0;
            tile_y_q <= 5'd0;
            wr_q     <= 1'b0;
            px_q     <= 8'd0;
            py_q     <= 9'd0;
            dat_q    <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            dir_q    <= dir_nxt;
            tile_x_q <= tile_x_nxt;
            tile_y_q <= tile_y_nxt;
            wr_q     <= wr_nxt;
            px_q     <= px_nxt;
            py_q     <= py_nxt;
            dat_q    <= dat_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_q;
        dir_nxt    = dir_q;
        tile_x_nxt = tile_x_q;
        tile_y_nxt = tile_y_q;
        wr_nxt     = wr_q;
        px_nxt     = px_q;
        py_nxt     = py_q;
        dat_nxt    = dat_q;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;
        err_nxt    = err_q;
        lat_load   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (tile_bad) begin
                        // Rejected request still completes with a done pulse.
                        err_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = FINISH;
                    end else begin
                        busy_nxt   = 1'b1;
                        addr_nxt   = 8'd0;
                        tile_x_nxt = bus.tileX;
                        tile_y_nxt = bus.tileY;
                        lat_load   = 1'b1;
                        state_nxt  = WAIT;
                        if (is_onehot4(bus.directionIn)) begin
                            dir_nxt = bus.directionIn;
                        end
                    end
                end
            end
            WAIT: begin
                if (sample) begin
                    if (TRANSPARENT_EN && (bus.pixelData == TRANSPARENT_COLOUR)) begin
                        if (last_pixel) begin
                            done_nxt  = 1'b1;
                            state_nxt = FINISH;
                        end else begin
                            addr_nxt = addr_q + 8'd1;
                            lat_load = 1'b1;
                        end
                    end else begin
                        dat_nxt   = bus.pixelData;
                        px_nxt    = {tile_x_q, addr_q[3:0]};
                        py_nxt    = {tile_y_q, addr_q[7:4]};
                        wr_nxt    = 1'b1;
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                if (bus.pixelReady) begin
                    wr_nxt = 1'b0;
                    if (last_pixel) begin
                        done_nxt  = 1'b1;
                        state_nxt = FINISH;
                    end else begin
                        addr_nxt  = addr_q + 8'd1;
                        lat_load  = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            FINISH: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.direction    = dir_q;
    assign bus.address      = addr_q;
    assign bus.pixelWrite   = wr_q;
    assign bus.pixelX       = px_q;
    assign bus.pixelY       = py_q;
    assign bus.pixelRawData = dat_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = err_q;

endmodule

// File: tb/tb_icon_blitter.sv
// Scoreboard bench for icon_blitter: a reference model queues expected writes per icon,
// a negedge monitor pops and compares every accepted pixel and checks hold/ordering rules.
module tb_icon_blitter;
    import icon_pkg::*;

    typedef struct {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
    } pix_t;

    logic clock;
    logic reset_n;
    icon_blitter_if bif();

    icon_blitter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif)
    );

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   accept_cyc;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   wr_cnt   = 0;
    bit   busy_seen;
    bit   stall_en = 1'b0;
    int   rom_mode = 0;
    pix_t sbq[$];
    pix_t got_q[$];

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_x;
    logic [8:0]  prev_y;
    logic [15:0] prev_d;
    logic        prev_addr_vld = 1'b0;
    logic [7:0]  prev_addr;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Behavioural rotator: pixel word as a function of the icon address.
    function automatic logic [15:0] pix(input int mode, input logic [7:0] a);
        case (mode)
            0:       return {8'h00, a};
            1:       return a[0] ? {8'h12, a} : RGB_MAGENTA;
            default: return {a ^ 8'h5A, 8'(a * 8'd37 + 8'd11)};
        endcase
    endfunction

    assign bif.pixelData = pix(rom_mode, bif.address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: every non-magenta pixel in raster order, at tile*16 + (col,row).
    task automatic push_icon(input int mode, input int tx, input int ty);
        for (int a = 0; a < ICON_PIXELS; a++) begin
            pix_t e;
            logic [15:0] d;
            d = pix(mode, 8'(a));
            if (d != RGB_MAGENTA) begin
                e.x = 8'(tx * ICON_SIZE + a % ICON_SIZE);
                e.y = 9'(ty * ICON_SIZE + a / ICON_SIZE);
                e.d = d;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input logic [3:0] tx, input logic [4:0] ty, input logic [3:0] dir);
        @(negedge clock);
        bif.start       = 1'b1;
        bif.tileX       = tx;
        bif.tileY       = ty;
        bif.directionIn = dir;
        @(posedge clock);
        #1;
        bif.start  = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_done(input string name, input int base, input int budget);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            @(posedge clock);
            k++;
        end
        chk({name, "_done_seen"}, 32'(done_cnt != base), 32'd1);
        repeat (4) @(posedge clock);
        chk({name, "_done_once"}, 32'(done_cnt - base), 32'd1);
        chk({name, "_queue_empty"}, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        bif.pixelReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            bif.pixelReady = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, hold-while-stalled and address ordering.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_stall    = 1'b0;
            prev_addr_vld = 1'b0;
        end else begin
            if (bif.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bif.busy) busy_seen = 1'b1;
            if (prev_stall) begin
                chk("hold_write", 32'(bif.pixelWrite), 32'd1);
                chk("hold_xy", 32'({bif.pixelX, bif.pixelY}), 32'({prev_x, prev_y}));
                chk("hold_data", 32'(bif.pixelRawData), 32'(prev_d));
            end
            if (bif.busy && prev_addr_vld)
                chk("addr_monotonic", 32'(bif.address >= prev_addr), 32'd1);
            prev_addr_vld = bif.busy;
            prev_addr     = bif.address;
            if (bif.pixelWrite && bif.pixelReady) begin
                pix_t g;
                g.x = bif.pixelX;
                g.y = bif.pixelY;
                g.d = bif.pixelRawData;
                got_q.push_back(g);
                wr_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    pix_t e;
                    e = sbq.pop_front();
                    chk("write_xy", 32'({g.x, g.y}), 32'({e.x, e.y}));
                    chk("write_data", 32'(g.d), 32'(e.d));
                end
            end
            prev_stall = bif.pixelWrite && !bif.pixelReady;
            prev_x     = bif.pixelX;
            prev_y     = bif.pixelY;
            prev_d     = bif.pixelRawData;
        end
    end

    initial begin
        int base;
        int wbase;
        int k;
        bit odd_ok;

        reset_n         = 1'b0;
        bif.start       = 1'b0;
        bif.tileX       = 4'd0;
        bif.tileY       = 5'd0;
        bif.directionIn = DIR_RIGHT;
        repeat (3) @(negedge clock);
        chk("rst_direction", 32'(bif.direction), 32'(DIR_RIGHT));
        chk("rst_address", 32'(bif.address), 32'd0);
        chk("rst_outputs", 32'({bif.pixelWrite, bif.busy, bif.done, bif.error}), 32'd0);
        chk("rst_pixel", 32'({bif.pixelX, bif.pixelY, bif.pixelRawData}), 32'd0);
        reset_n = 1'b1;

        // Full icon, sink always ready, pixelData = address.
        rom_mode = 0;
        got_q.delete();
        push_icon(0, 2, 3);
        base = done_cnt;
        pulse_start(4'd2, 5'd3, DIR_RIGHT);
        chk("t1_busy_at_accept", 32'(bif.busy), 32'd1);
        wait_done("t1", base, 2000);
        chk("t1_writes", 32'(got_q.size()), 32'd256);
        chk("t1_first", 32'({got_q[0].x, got_q[0].y, got_q[0].d[6:0]}), 32'({8'd32, 9'd48, 7'd0}));
        chk("t1_last", 32'({got_q[$].x, got_q[$].y, got_q[$].d[14:0]}), 32'({8'd47, 9'd63, 15'h00FF}));
        chk("t1_done_latency", 32'(done_cyc - accept_cyc), 32'd512);
        chk("t1_idle_after", 32'({bif.busy, bif.address}), 32'({1'b0, 8'hFF}));

        // Random stalls, mid-icon heading change and ignored restart.
        rom_mode = 2;
        stall_en = 1'b1;
        got_q.delete();
        begin
            logic [3:0] tx;
            logic [4:0] ty;
            tx = 4'($urandom_range(0, 14));
            ty = 5'($urandom_range(0, 19));
            push_icon(2, int'(tx), int'(ty));
            base = done_cnt;
            pulse_start(tx, ty, DIR_RIGHT);
        end
        repeat (60) @(posedge clock);
        bif.directionIn = DIR_LEFT;
        pulse_start(4'd0, 5'd0, DIR_LEFT);
        chk("t2_dir_mid", 32'(bif.direction), 32'(DIR_RIGHT));
        chk("t2_busy_mid", 32'(bif.busy), 32'd1);
        wait_done("t2", base, 6000);
        chk("t2_writes", 32'(got_q.size()), 32'd256);
        chk("t2_dir_end", 32'(bif.direction), 32'(DIR_RIGHT));
        stall_en = 1'b0;

        // Magenta on even addresses: only odd columns written.
        rom_mode = 1;
        got_q.delete();
        push_icon(1, 7, 11);
        base = done_cnt;
        pulse_start(4'd7, 5'd11, DIR_LEFT);
        wait_done("t3", base, 2000);
        chk("t3_writes", 32'(got_q.size()), 32'd128);
        odd_ok = 1'b1;
        foreach (got_q[i]) if (got_q[i].x[0] != 1'b1) odd_ok = 1'b0;
        chk("t3_odd_cols", 32'(odd_ok), 32'd1);
        chk("t3_direction", 32'(bif.direction), 32'(DIR_LEFT));

        // Non-one-hot heading keeps the previous direction.
        rom_mode = 0;
        got_q.delete();
        push_icon(0, 1, 1);
        base = done_cnt;
        pulse_start(4'd1, 5'd1, 4'b0011);
        chk("t4_dir_kept", 32'(bif.direction), 32'(DIR_LEFT));
        wait_done("t4", base, 2000);
        chk("t4_writes", 32'(got_q.size()), 32'd256);

        // Out-of-range tiles are rejected.
        chk("t5_error_before", 32'(bif.error), 32'd0);
        wbase     = wr_cnt;
        busy_seen = 1'b0;
        base      = done_cnt;
        pulse_start(4'd15, 5'd0, DIR_RIGHT);
        chk("t5_error_x", 32'({bif.error, bif.done}), 32'b11);
        wait_done("t5x", base, 10);
        base = done_cnt;
        pulse_start(4'd0, 5'd20, DIR_RIGHT);
        wait_done("t5y", base, 10);
        chk("t5_no_writes", 32'(wr_cnt - wbase), 32'd0);
        chk("t5_busy_never", 32'(busy_seen), 32'd0);
        chk("t5_error_sticky", 32'(bif.error), 32'd1);

        // Reset at pixel 100 abandons the icon; redraw starts from address 0.
        stall_en = 1'b1;
        got_q.delete();
        push_icon(0, 4, 5);
        wbase = wr_cnt;
        pulse_start(4'd4, 5'd5, DIR_DOWN);
        k = 0;
        while (wr_cnt - wbase < 100 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        chk("t6_reached_100", 32'(wr_cnt - wbase >= 100), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_dir", 32'(bif.direction), 32'(DIR_RIGHT));
        chk("t6_async_ctrl", 32'({bif.pixelWrite, bif.busy, bif.done, bif.error}), 32'd0);
        chk("t6_async_pix", 32'({bif.address, bif.pixelX, bif.pixelY, bif.pixelRawData}), 32'd0);
        sbq.delete();
        stall_en = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        base  = done_cnt;
        wbase = wr_cnt;
        repeat (6) @(negedge clock);
        chk("t6_quiet_after", 32'({done_cnt - base, wr_cnt - wbase}), 32'd0);
        got_q.delete();
        push_icon(0, 4, 5);
        pulse_start(4'd4, 5'd5, DIR_DOWN);
        chk("t6_restart_addr", 32'(bif.address), 32'd0);
        wait_done("t6", base, 2000);
        chk("t6_writes", 32'(got_q.size()), 32'd256);
        chk("t6_first", 32'({got_q[0].x, got_q[0].y}), 32'({8'd64, 9'd80}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
